// File: rtl/des_key_pkg.sv
// DES key-schedule constants: PC-1/PC-2 permutations, shift-by-1 round mask,
// controller state encoding and a 28-bit half-key rotate helper.
package des_key_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  // Bit n set means round n rotates by one position instead of two.
  localparam logic [15:0] SHIFT1_MASK = 16'b1000_0001_0000_0011;

  // Entries are DES bit numbers, 1 = MSB of the source word.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key64);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key64[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd56);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd56[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                        input logic one);
    logic [27:0] r;
    if (left) r = one ? {x[26:0], x[27]}   : {x[25:0], x[27:26]};
    else      r = one ? {x[0],    x[27:1]} : {x[1:0],  x[27:2]};
    return r;
  endfunction

endpackage

// File: rtl/des_key_sched_ctrl_rot.sv
// Combinational per-round step: rotate C/D by 1 or 2 in the chosen direction
// and derive the round key from the rotated halves.
module des_key_sched_ctrl_rot
  import des_key_pkg::*;
(
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic        dir_left_i,
  input  logic        shift1_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o,
  output logic [47:0] rk_o
);

  assign c_o  = rot28(c_i, dir_left_i, shift1_i);
  assign d_o  = rot28(d_i, dir_left_i, shift1_i);
  assign rk_o = pc2({c_o, d_o});

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: loads PC1(key), then streams 16 round keys one
// per valid/ready handshake (K1..K16 encrypt, K16..K1 decrypt).
module des_key_sched_ctrl
  import des_key_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic        i_encrypt,
  input  logic        i_abort,
  input  logic        i_rk_ready,
  output logic [47:0] o_rk,
  output logic        o_rk_valid,
  output logic [3:0]  o_rk_idx,
  output logic        o_encrypt,
  output logic        o_busy,
  output logic        o_done
);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        enc_q, enc_d;

  logic [27:0] c_rot, d_rot;
  logic [55:0] pc1_key;

  assign pc1_key = pc1(i_key);

  des_key_sched_ctrl_rot u_rot (
    .c_i        (c_q),
    .d_i        (d_q),
    .dir_left_i (enc_q),
    .shift1_i   (SHIFT1_MASK[round_q]),
    .c_o        (c_rot),
    .d_o        (d_rot),
    .rk_o       (o_rk)
  );

  assign o_rk_valid = (state_q == ROUND);
  assign o_busy     = (state_q == ROUND);
  assign o_done     = (state_q == DONE);
  assign o_rk_idx   = round_q;
  assign o_encrypt  = enc_q;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    enc_d   = enc_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          // Decrypt pre-rotates left by one so the first right step lands on C0/D0.
          if (i_encrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rot28(pc1_key[55:28], 1'b1, 1'b1);
            d_d = rot28(pc1_key[27:0],  1'b1, 1'b1);
          end
          round_d = 4'd0;
          enc_d   = i_encrypt;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_rk_ready) begin
          c_d     = c_rot;
          d_d     = d_rot;
          round_d = round_q + 4'd1;
          if (round_q == 4'd15) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      enc_q   <= enc_d;
    end
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl: known DES schedules, stall, abort,
// ignored restart and asynchronous reset mid-schedule.
module tb_des_key_sched_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [63:0] i_key;
  logic        i_encrypt;
  logic        i_abort;
  logic        i_rk_ready;
  logic [47:0] o_rk;
  logic        o_rk_valid;
  logic [3:0]  o_rk_idx;
  logic        o_encrypt;
  logic        o_busy;
  logic        o_done;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;
  localparam logic [47:0] A_K1    = 48'h1B02EFFC7072;
  localparam logic [47:0] A_K2    = 48'h79AED9DBC9E5;
  localparam logic [47:0] A_K16   = 48'hCB3D8B0E17F5;
  localparam logic [47:0] B_K16   = 48'hCA3D03B87032;

  int total = 0;
  int bad   = 0;
  logic [47:0] enc_k [16];

  des_key_sched_ctrl dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_key      (i_key),
    .i_encrypt  (i_encrypt),
    .i_abort    (i_abort),
    .i_rk_ready (i_rk_ready),
    .o_rk       (o_rk),
    .o_rk_valid (o_rk_valid),
    .o_rk_idx   (o_rk_idx),
    .o_encrypt  (o_encrypt),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_key      = '0;
    i_encrypt  = 1'b0;
    i_abort    = 1'b0;
    i_rk_ready = 1'b0;
    for (int i = 0; i < 16; i++) enc_k[i] = '0;
    tick(); tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // 1: idle after reset
    chk("reset_valid", o_rk_valid, 0);
    chk("reset_busy",  o_busy,     0);
    chk("reset_done",  o_done,     0);
    chk("reset_rk",    o_rk,       0);
    chk("reset_enc",   o_encrypt,  0);

    // 2: encrypt KEY_A, consumer always ready
    i_start = 1'b1; i_key = KEY_A; i_encrypt = 1'b1; i_rk_ready = 1'b1;
    tick();
    i_start = 1'b0;
    chk("enc_busy", o_busy, 1);
    chk("enc_mode", o_encrypt, 1);
    for (int i = 0; i < 16; i++) begin
      chk("enc_valid", o_rk_valid, 1);
      chk("enc_idx",   o_rk_idx, i);
      enc_k[i] = o_rk;
      tick();
    end
    chk("enc_k1",  enc_k[0],  A_K1);
    chk("enc_k2",  enc_k[1],  A_K2);
    chk("enc_k16", enc_k[15], A_K16);
    chk("enc_done_pulse", o_done, 1);
    chk("enc_done_valid", o_rk_valid, 0);
    tick();
    chk("enc_done_clear", o_done, 0);
    chk("enc_idle_busy",  o_busy, 0);

    // 3: decrypt KEY_A gives the encrypt keys reversed
    i_start = 1'b1; i_encrypt = 1'b0;
    tick();
    i_start = 1'b0;
    chk("dec_mode", o_encrypt, 0);
    for (int i = 0; i < 16; i++) begin
      chk("dec_valid", o_rk_valid, 1);
      chk("dec_idx",   o_rk_idx, i);
      chk("dec_rev",   o_rk, enc_k[15-i]);
      if (i == 0)  chk("dec_idx0",  o_rk, A_K16);
      if (i == 14) chk("dec_idx14", o_rk, A_K2);
      if (i == 15) chk("dec_idx15", o_rk, A_K1);
      tick();
    end
    chk("dec_done", o_done, 1);
    tick();

    // 4: encrypt with a 3-cycle stall at idx4
    i_start = 1'b1; i_encrypt = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("stall_idx", o_rk_idx, i);
      chk("stall_rk",  o_rk, enc_k[i]);
      if (i == 4) begin
        i_rk_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_hold_valid", o_rk_valid, 1);
          chk("stall_hold_idx",   o_rk_idx, 4);
          chk("stall_hold_rk",    o_rk, enc_k[4]);
        end
        i_rk_ready = 1'b1;
      end
      tick();
    end
    chk("stall_done", o_done, 1);
    tick();

    // 5: abort on the idx7 handshake, then decrypt KEY_B
    i_start = 1'b1; i_encrypt = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_at_idx", o_rk_idx, 7);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_valid", o_rk_valid, 0);
    chk("abort_busy",  o_busy, 0);
    chk("abort_nodone", o_done, 0);
    chk("abort_idx_kept", o_rk_idx, 7);
    chk("abort_rk_kept",  o_rk, enc_k[7]);
    i_start = 1'b1; i_key = KEY_B; i_encrypt = 1'b0;
    tick();
    i_start = 1'b0;
    chk("b_dec_idx0", o_rk_idx, 0);
    chk("b_dec_k16",  o_rk, B_K16);
    chk("b_dec_mode", o_encrypt, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("b_dec_done", o_done, 1);
    tick();

    // 6: start ignored mid-schedule, then async reset at idx9
    i_start = 1'b1; i_key = KEY_A; i_encrypt = 1'b1;
    tick();
    i_start = 1'b1; i_encrypt = 1'b0;
    tick();
    i_start = 1'b0;
    chk("ign_idx",  o_rk_idx, 1);
    chk("ign_mode", o_encrypt, 1);
    chk("ign_rk",   o_rk, enc_k[1]);
    for (int i = 1; i < 9; i++) tick();
    chk("rst_at_idx", o_rk_idx, 9);
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_rk_valid, 0);
    chk("arst_busy",  o_busy, 0);
    chk("arst_rk",    o_rk, 0);
    chk("arst_idx",   o_rk_idx, 0);
    chk("arst_mode",  o_encrypt, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    // start and abort together in IDLE: start wins
    i_start = 1'b1; i_abort = 1'b1; i_encrypt = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    chk("restart_valid", o_rk_valid, 1);
    chk("restart_idx",   o_rk_idx, 0);
    chk("restart_rk",    o_rk, A_K1);
    for (int i = 0; i < 16; i++) tick();
    chk("restart_done", o_done, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
Sequences the DES key schedule for one 64-bit key and emits the sixteen 48-bit round keys to the cipher datapath, one per valid/ready handshake. It owns the C/D half-key registers and the round counter, and it applies PC-1 on load. Per-round rotation and PC-2 run in a combinational sub-module. Encrypt order is K1..K16; decrypt order is K16..K1, built with right rotations. The block sits between the key-load interface and the round pipeline.

Parameters:
None. DES is fixed at 16 rounds; the round index is 4 bits.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  load request; sampled only in IDLE
i_key  input  64  DES key, bit 63 = DES bit 1; parity bits ignored by PC-1
i_encrypt  input  1  1 = encrypt schedule, 0 = decrypt; sampled with i_start
i_abort  input  1  synchronous abort; cancels the schedule in progress
i_rk_ready  input  1  consumer accepts o_rk this cycle
o_rk  output  48  current round key (PC-2 output)
o_rk_valid  output  1  o_rk is valid
o_rk_idx  output  4  emission index 0..15
o_encrypt  output  1  latched mode for the running schedule
o_busy  output  1  high in ROUND state
o_done  output  1  one-cycle pulse after the 16th key is accepted

Behaviour:
- Reset (async, i_rst_n=0): state goes to IDLE; c_q, d_q, round_q, o_rk_valid, o_busy, o_done and o_encrypt all clear to 0. o_rk is PC-2 of the zero registers, which is 0.
- States: IDLE, ROUND, DONE.
- IDLE with i_start=1:
  - {c_q,d_q} loads PC1(i_key).
  - If i_encrypt=0, each half is additionally rotated left by 1 (pre-load), so the first right rotation restores C0/D0.
  - round_q loads 0, o_encrypt loads i_encrypt, and the state moves to ROUND.
  - The first o_rk_valid is asserted the cycle after i_start (latency 1).
- ROUND:
  - o_rk_valid=1, o_rk = PC2(rot(c_q,d_q)), o_rk_idx = round_q.
  - Rotation amount: 1 when round_q is in {0,1,8,15}, otherwise 2.
  - Direction: left when o_encrypt=1, right when o_encrypt=0.
  - On valid & ready: {c_q,d_q} <= rot(c_q,d_q) and round_q increments.
  - If round_q==15 at the handshake, the next state is DONE.
  - Without ready, o_rk and o_rk_idx hold stable (no bubble, no change).
- DONE: o_done=1 and o_rk_valid=0 for exactly one cycle, then IDLE.
- Back-to-back: i_start in the DONE cycle is ignored. Restart requires IDLE, so the minimum gap is 1 idle cycle.
- i_start outside IDLE is ignored, and o_encrypt does not change mid-schedule.
- i_abort in ROUND or DONE: the next state is IDLE, o_rk_valid drops next cycle and no o_done is issued.
  - If abort coincides with a handshake, abort wins: round_q and C/D are not updated. The consumer must discard that key.
- i_abort in IDLE is a no-op. If i_abort and i_start are both high in IDLE, i_start wins.
- Wrap: C/D arithmetic is pure rotation within 28 bits. After 16 encrypt rounds C/D equal PC1 (total rotation 28); after 16 decrypt rounds they equal the pre-loaded value.
- Reset mid-schedule: immediate IDLE; o_rk_valid falls asynchronously.

Decomposition:
- Package des_key_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constant arrays.
  - Function pc1(key64).
  - Function pc2(cd56).
  - Shift-1 round mask 16'b1000_0001_0000_0011, bit n = round n.
  - State enum {IDLE, ROUND, DONE}.
- Sub-module des_key_rot: combinational. Inputs are c, d, dir, shift-by-1 flag. Outputs are rotated c, rotated d and the PC-2 round key.
- The controller holds all registers and the FSM.

Test Plan:
1. Reset released, idle 5 cycles -> o_rk_valid=0, o_busy=0, o_done=0, o_rk=0.
2. Encrypt key 0x133457799BBCDFF1, ready=1 -> PC1 gives C0=0xF0CCAAF, D0=0x556678F; keys stream one per cycle: idx0=0x1B02EFFC7072, idx1=0x79AED9DBC9E5, idx15=0xCB3D8B0E17F5; o_done pulses 1 cycle after idx15.
3. Decrypt with the same key, ready=1 -> idx0=0xCB3D8B0E17F5, idx14=0x79AED9DBC9E5, idx15=0x1B02EFFC7072; all 16 keys match the encrypt run in reverse order.
4. Encrypt with ready held low 3 cycles at idx4 -> o_rk and o_rk_idx stay stable for 3 cycles, then stepping resumes; 16 keys total, no duplicates or skips.
5. Abort coinciding with the idx7 handshake, then i_start (decrypt, key 0x0123456789ABCDEF) -> IDLE with no o_done; the new run's idx0 equals that key's encrypt K16.
6. i_start pulsed during ROUND, and reset asserted at idx9 -> i_start is ignored with o_encrypt unchanged; on reset all outputs clear asynchronously and a new start restarts at idx0.
